// File: rtl/islemci_run_checker_pkg.sv
// Shared definitions for the islemci run checker: FSM state type and
// the fail-index width helper used by the top and the comparator.
package islemci_run_checker_pkg;

  // Encodings are kept identical to the original header values.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned MAX_CHK = 16;

  // One extra bit beyond the channel index so all-ones never aliases a
  // real channel number (the FAIL_NONE value).
  function automatic int unsigned fail_idx_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/islemci_run_checker_cmp.sv
// Purely combinational compare of captured result registers against
// expected values. all_pass_o covers masked channels only; first_fail_o
// is the lowest masked mismatching channel, all-ones when there is none.
module islemci_chk_cmp
  import islemci_run_checker_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_CHK = 4
) (
  input  logic [NUM_CHK*DATA_W-1:0]        data_i,
  input  logic [NUM_CHK*DATA_W-1:0]        exp_i,
  input  logic [NUM_CHK-1:0]               mask_i,
  output logic                             all_pass_o,
  output logic [fail_idx_w(NUM_CHK)-1:0]   first_fail_o
);

  localparam int unsigned FW = fail_idx_w(NUM_CHK);

  logic found;

  // Priority encoder over masked mismatches; the first hit in ascending
  // order is latched by 'found' so the lowest index wins.
  always_comb begin
    all_pass_o   = 1'b1;
    first_fail_o = '1;
    found        = 1'b0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      if (mask_i[i] && (data_i[i*DATA_W +: DATA_W] != exp_i[i*DATA_W +: DATA_W])) begin
        all_pass_o = 1'b0;
        if (!found) begin
          first_fail_o = i[FW-1:0];
          found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/islemci_run_checker.sv
// Run controller / self-checker for the islemci core. Launches a run via
// the core valid handshake, counts RUN cycles, then either compares the
// captured result registers or reports a timeout.
module islemci_run_checker
  import islemci_run_checker_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_CHK    = 4,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned HOLD_VALID = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           core_valid_in,
  input  logic                           core_valid_out,
  input  logic [NUM_CHK*DATA_W-1:0]      chk_data,
  input  logic [NUM_CHK*DATA_W-1:0]      exp_data,
  input  logic [NUM_CHK-1:0]             chk_mask,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [fail_idx_w(NUM_CHK)-1:0] fail_idx,
  output logic [CNT_W-1:0]               cycle_count
);

  localparam int unsigned      FW       = fail_idx_w(NUM_CHK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e                      state_q, state_d;
  logic                        first_q, first_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic                        timeout_q, timeout_d;
  logic [FW-1:0]               fidx_q, fidx_d;
  logic [NUM_CHK*DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [NUM_CHK*DATA_W-1:0]   cap_exp_q, cap_exp_d;
  logic [NUM_CHK-1:0]          cap_mask_q, cap_mask_d;

  logic                        cmp_pass;
  logic [FW-1:0]               cmp_fail;

  islemci_chk_cmp #(
    .DATA_W  (DATA_W),
    .NUM_CHK (NUM_CHK)
  ) u_cmp (
    .data_i       (cap_data_q),
    .exp_i        (cap_exp_q),
    .mask_i       (cap_mask_q),
    .all_pass_o   (cmp_pass),
    .first_fail_o (cmp_fail)
  );

  // State, counter, result flags and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fidx_q     <= '1;
      cap_data_q <= '0;
      cap_exp_q  <= '0;
      cap_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fidx_q     <= fidx_d;
      cap_data_q <= cap_data_d;
      cap_exp_q  <= cap_exp_d;
      cap_mask_q <= cap_mask_d;
    end
  end

  // Next-state logic and core_valid_in. core_valid_in is decoded from the
  // registered state so an async reset drops it without waiting for a clock.
  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fidx_d        = fidx_q;
    cap_data_d    = cap_data_q;
    cap_exp_d     = cap_exp_q;
    cap_mask_d    = cap_mask_q;
    core_valid_in = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
        fidx_d    = '1;
        if (start) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end
      end

      ST_RUN: begin
        core_valid_in = (HOLD_VALID != 0) || first_q;
        first_d       = 1'b0;
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Completion takes priority over a timeout in the same cycle.
        if (core_valid_out) begin
          state_d    = ST_CHECK;
          cap_data_d = chk_data;
          cap_exp_d  = exp_data;
          cap_mask_d = chk_mask;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end

      ST_CHECK: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = cmp_pass;
        fidx_d  = cmp_fail;
      end

      ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          first_d   = 1'b1;
          cnt_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fidx_d    = '1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_idx    = fidx_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_islemci_run_checker.sv
// Randomized self-checking bench for islemci_run_checker. Two instances:
// A (4 channels, short timeout, held valid) and B (1 channel, default
// timeout, pulsed valid). Expected results come from a run-level model.
module tb_islemci_run_checker;

  localparam int A_TO = 20;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_start, a_vin, a_vout, a_done, a_pass, a_to;
  logic [63:0] a_chk, a_exp;
  logic [3:0]  a_mask;
  logic [2:0]  a_fidx;
  logic [23:0] a_cnt;

  logic        b_start, b_vin, b_vout, b_done, b_pass, b_to;
  logic [15:0] b_chk, b_exp;
  logic [0:0]  b_mask;
  logic [0:0]  b_fidx;
  logic [23:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  islemci_run_checker #(
    .DATA_W(16), .NUM_CHK(4), .CNT_W(24), .TIMEOUT(A_TO), .HOLD_VALID(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .core_valid_in(a_vin),
    .core_valid_out(a_vout), .chk_data(a_chk), .exp_data(a_exp), .chk_mask(a_mask),
    .done(a_done), .pass(a_pass), .timeout(a_to), .fail_idx(a_fidx), .cycle_count(a_cnt)
  );

  islemci_run_checker #(
    .DATA_W(16), .NUM_CHK(1), .CNT_W(24), .TIMEOUT(100000), .HOLD_VALID(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .core_valid_in(b_vin),
    .core_valid_out(b_vout), .chk_data(b_chk), .exp_data(b_exp), .chk_mask(b_mask),
    .done(b_done), .pass(b_pass), .timeout(b_to), .fail_idx(b_fidx), .cycle_count(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run-level reference: the core finishes in RUN cycle 'lat' unless the
  // timeout (RUN cycle A_TO) comes first; a tie goes to completion.
  task automatic model_a(input int lat, input logic [63:0] d, input logic [63:0] e,
                         input logic [3:0] m, output bit pass_o, output logic [2:0] fidx_o,
                         output bit to_o, output int cnt_o, output int waits_o);
    to_o   = (lat > A_TO);
    pass_o = !to_o;
    fidx_o = 3'b111;
    if (to_o) begin
      cnt_o   = A_TO;
      waits_o = A_TO;
    end else begin
      cnt_o   = lat;
      waits_o = lat + 1;
      for (int i = 3; i >= 0; i--) begin
        if (m[i] && (d[i*16 +: 16] != e[i*16 +: 16])) begin
          pass_o = 1'b0;
          fidx_o = 3'(i);
        end
      end
    end
  endtask

  task automatic run_a(input string tag, input int lat, input logic [63:0] d,
                       input logic [63:0] e, input logic [3:0] m);
    bit ep, eto;
    logic [2:0] ef;
    int ec, ew, k, vin, run_cycles;
    logic p_hold;
    model_a(lat, d, e, m, ep, ef, eto, ec, ew);
    run_cycles = eto ? A_TO : lat;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check_eq({tag, "_clr_done"}, 32'(a_done), 32'd0);
    check_eq({tag, "_clr_cnt"}, 32'(a_cnt), 32'd0);
    check_eq({tag, "_clr_to"}, 32'(a_to), 32'd0);
    k = 0;
    vin = 0;
    while (a_done !== 1'b1 && k < 200) begin
      if (a_vin === 1'b1) vin++;
      a_start = 1'($urandom_range(0, 1));
      if (k == lat - 1) begin
        a_vout = 1'b1; a_chk = d; a_exp = e; a_mask = m;
      end
      @(negedge clk);
      k++;
      if (k == lat) begin
        a_vout = 1'b0;
        a_chk  = {$urandom, $urandom};
        a_exp  = {$urandom, $urandom};
        a_mask = 4'($urandom);
      end
    end
    a_start = 1'b0;
    check_eq({tag, "_latency"}, 32'(k), 32'(ew));
    check_eq({tag, "_done"}, 32'(a_done), 32'd1);
    check_eq({tag, "_pass"}, 32'(a_pass), 32'(ep));
    check_eq({tag, "_timeout"}, 32'(a_to), 32'(eto));
    check_eq({tag, "_fidx"}, 32'(a_fidx), 32'(ef));
    check_eq({tag, "_cnt"}, 32'(a_cnt), 32'(ec));
    check_eq({tag, "_vin_cycles"}, 32'(vin), 32'(run_cycles));
    check_eq({tag, "_vin_done"}, 32'(a_vin), 32'd0);
    // Results must hold in DONE even if the core pulses valid_out again.
    p_hold = a_pass;
    a_vout = 1'b1;
    @(negedge clk);
    a_vout = 1'b0;
    @(negedge clk);
    check_eq({tag, "_hold_done"}, 32'(a_done), 32'd1);
    check_eq({tag, "_hold_pass"}, 32'(a_pass), 32'(p_hold));
    check_eq({tag, "_hold_cnt"}, 32'(a_cnt), 32'(ec));
  endtask

  task automatic run_b(input string tag, input int lat, input logic [15:0] d,
                       input logic [15:0] e);
    int k, vin;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check_eq({tag, "_clr_cnt"}, 32'(b_cnt), 32'd0);
    k = 0;
    vin = 0;
    while (b_done !== 1'b1 && k < 200) begin
      if (b_vin === 1'b1) vin++;
      if (k == lat - 1) begin
        b_vout = 1'b1; b_chk = d; b_exp = e; b_mask = 1'b1;
      end
      @(negedge clk);
      k++;
      if (k == lat) begin
        b_vout = 1'b0;
        b_chk  = 16'($urandom);
        b_exp  = 16'($urandom);
        b_mask = 1'($urandom);
      end
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(lat + 1));
    check_eq({tag, "_done"}, 32'(b_done), 32'd1);
    check_eq({tag, "_pass"}, 32'(b_pass), 32'(d == e));
    check_eq({tag, "_timeout"}, 32'(b_to), 32'd0);
    check_eq({tag, "_fidx"}, 32'(b_fidx), (d == e) ? 32'd1 : 32'd0);
    check_eq({tag, "_cnt"}, 32'(b_cnt), 32'(lat));
    check_eq({tag, "_vin_pulse"}, 32'(vin), 32'd1);
    check_eq({tag, "_vin_done"}, 32'(b_vin), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] e, d;
    logic [3:0]  m;
    rst_n = 1'b0;
    a_start = 1'b0; a_vout = 1'b0; a_chk = '0; a_exp = '0; a_mask = '0;
    b_start = 1'b0; b_vout = 1'b0; b_chk = '0; b_exp = '0; b_mask = '0;
    #23;
    check_eq("rst_a_done", 32'(a_done), 32'd0);
    check_eq("rst_a_pass", 32'(a_pass), 32'd0);
    check_eq("rst_a_to", 32'(a_to), 32'd0);
    check_eq("rst_a_fidx", 32'(a_fidx), 32'h7);
    check_eq("rst_a_cnt", 32'(a_cnt), 32'd0);
    check_eq("rst_a_vin", 32'(a_vin), 32'd0);
    check_eq("rst_b_fidx", 32'(b_fidx), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel, pulsed valid.
    run_b("t1", 50, 16'h004c, 16'h004c);
    run_b("t2", 50, 16'h004d, 16'h004c);

    // Masked channels: ch1 ok, ch3 wrong, ch0/ch2 garbage.
    e = 64'h3333_2222_1111_0000;
    d = 64'h3334_abcd_1111_dead;
    run_a("t3a", 7, d, e, 4'b1010);
    run_a("t3b", 7, d, e, 4'b0010);
    run_a("mask0", 3, d, e, 4'b0000);
    run_a("fidx0", 2, d, e, 4'b1111);

    // Timeout, then restart from DONE.
    run_a("t4", 1000, e, e, 4'b1111);
    run_a("t4re", 5, e, e, 4'b1111);

    // Completion on the last permitted cycle vs one cycle too late.
    run_a("t5", A_TO, e, e, 4'b1111);
    run_a("t5late", A_TO + 1, e, e, 4'b1111);
    run_a("lat1", 1, d, e, 4'b0110);

    for (int n = 0; n < 40; n++) begin
      e = {$urandom, $urandom};
      m = 4'($urandom);
      d = e;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 1) == 1) d[c*16 + $urandom_range(0, 15)] ^= 1'b1;
      run_a("rnd", $urandom_range(1, A_TO + 4), d, e, m);
    end

    // Reset in the middle of a run on A.
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t6_vin_before", 32'(a_vin), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_vin_async", 32'(a_vin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6_done", 32'(a_done), 32'd0);
    check_eq("t6_cnt", 32'(a_cnt), 32'd0);
    check_eq("t6_fidx", 32'(a_fidx), 32'h7);
    check_eq("t6_vin_idle", 32'(a_vin), 32'd0);
    run_a("t6post", 9, d, d, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
